// File: rtl/pipe_control_unit.sv
// pipe_control_unit: pipelined MIPS main-decoder / hazard controller.
// Decodes the ID opcode, carries the control bundle through ID/EX, EX/MEM and
// MEM/WB, detects load-use (and, without forwarding, RAW) hazards, resolves
// BEQ/BNE in EX and J in ID, and counts stall / flush cycles (saturating).
// Optional build macro: PIPE_CTRL_FORWARD_EN enables the forwarding unit;
// when undefined fwd_a/fwd_b are 00 and EX/MEM producers also stall ID.
module pipe_control_unit #(
  parameter int unsigned OP_W   = 6,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_dst,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        pc_sel,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);

  // decoded ID bundle
  logic       dec_reg_dst, dec_alu_src, dec_mem_read, dec_mem_write;
  logic       dec_reg_write, dec_mem_to_reg, dec_branch, dec_branch_not, dec_jump;
  logic [1:0] dec_alu_op;

  // ID/EX
  logic              ex_reg_dst_q, ex_reg_dst_d, ex_alu_src_q, ex_alu_src_d;
  logic [1:0]        ex_alu_op_q, ex_alu_op_d;
  logic              ex_mem_read_q, ex_mem_read_d, ex_mem_write_q, ex_mem_write_d;
  logic              ex_reg_write_q, ex_reg_write_d, ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic              ex_branch_q, ex_branch_d, ex_branch_not_q, ex_branch_not_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  // EX/MEM
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic              mem_reg_write_q, mem_reg_write_d, mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic [REG_AW-1:0] mem_dst_q, mem_dst_d;
  // MEM/WB
  logic              wb_reg_write_q, wb_reg_write_d, wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [REG_AW-1:0] wb_dst_q, wb_dst_d;
  // counters
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [REG_AW-1:0] ex_dst;
  logic              hit_ex, stall_req, br_taken, stall, jump, bubble;

  // main decoder, same table as the single-cycle version
  always_comb begin
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op     = 2'b00;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_branch     = 1'b0;
    dec_branch_not = 1'b0;
    dec_jump       = 1'b0;
    case (id_opcode)
      OP_R:    begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_alu_op = 2'b10; end
      OP_LW:   begin
                 dec_reg_write = 1'b1; dec_alu_src = 1'b1;
                 dec_mem_read = 1'b1; dec_mem_to_reg = 1'b1;
               end
      OP_SW:   begin dec_alu_src = 1'b1; dec_mem_write = 1'b1; end
      OP_BEQ:  dec_branch = 1'b1;
      OP_BNE:  dec_branch_not = 1'b1;
      OP_J:    dec_jump = 1'b1;
      OP_ADDI: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 2'b00; end
      OP_ANDI: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 2'b11; end
      default: ;
    endcase
  end

  // hazard detection, branch/jump resolution and pipeline enables
  always_comb begin
    ex_dst    = ex_reg_dst_q ? ex_rd_q : ex_rt_q;
    hit_ex    = (ex_dst != '0) && ((ex_dst == id_rs) || (ex_dst == id_rt));
    stall_req = ex_mem_read_q && hit_ex;
`ifndef PIPE_CTRL_FORWARD_EN
    // without forwarding any in-flight producer in EX or MEM blocks ID
    stall_req = stall_req || (ex_reg_write_q && hit_ex) ||
                (mem_reg_write_q && (mem_dst_q != '0) &&
                 ((mem_dst_q == id_rs) || (mem_dst_q == id_rt)));
`endif
    br_taken   = (ex_branch_q && ex_zero) || (ex_branch_not_q && !ex_zero);
    stall      = stall_req && !br_taken;
    jump       = dec_jump && !stall && !br_taken;
    bubble     = stall || br_taken;
    pc_write   = !stall;
    ifid_write = !stall;
    ifid_flush = br_taken || jump;
    pc_sel     = br_taken ? 2'b01 : (jump ? 2'b10 : 2'b00);
  end

`ifdef PIPE_CTRL_FORWARD_EN
  // forwarding unit: EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_reg_write_q && (mem_dst_q != '0) && (mem_dst_q == ex_rs_q)) fwd_a = 2'b10;
    else if (wb_reg_write_q && (wb_dst_q != '0) && (wb_dst_q == ex_rs_q)) fwd_a = 2'b01;
    if (mem_reg_write_q && (mem_dst_q != '0) && (mem_dst_q == ex_rt_q)) fwd_b = 2'b10;
    else if (wb_reg_write_q && (wb_dst_q != '0) && (wb_dst_q == ex_rt_q)) fwd_b = 2'b01;
  end
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // next-state for pipeline registers and counters
  always_comb begin
    ex_reg_dst_d     = bubble ? 1'b0 : dec_reg_dst;
    ex_alu_src_d     = bubble ? 1'b0 : dec_alu_src;
    ex_alu_op_d      = bubble ? 2'b00 : dec_alu_op;
    ex_mem_read_d    = bubble ? 1'b0 : dec_mem_read;
    ex_mem_write_d   = bubble ? 1'b0 : dec_mem_write;
    ex_reg_write_d   = bubble ? 1'b0 : dec_reg_write;
    ex_mem_to_reg_d  = bubble ? 1'b0 : dec_mem_to_reg;
    ex_branch_d      = bubble ? 1'b0 : dec_branch;
    ex_branch_not_d  = bubble ? 1'b0 : dec_branch_not;
    ex_rs_d          = bubble ? '0 : id_rs;
    ex_rt_d          = bubble ? '0 : id_rt;
    ex_rd_d          = bubble ? '0 : id_rd;
    mem_read_d       = ex_mem_read_q;
    mem_write_d      = ex_mem_write_q;
    mem_reg_write_d  = ex_reg_write_q;
    mem_mem_to_reg_d = ex_mem_to_reg_q;
    mem_dst_d        = ex_dst;
    wb_reg_write_d   = mem_reg_write_q;
    wb_mem_to_reg_d  = mem_mem_to_reg_q;
    wb_dst_d         = mem_dst_q;
    stall_cnt_d      = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d      = (ifid_flush && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // state registers; reset empties every stage and clears the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg_dst_q     <= 1'b0;  ex_alu_src_q    <= 1'b0;  ex_alu_op_q <= 2'b00;
      ex_mem_read_q    <= 1'b0;  ex_mem_write_q  <= 1'b0;
      ex_reg_write_q   <= 1'b0;  ex_mem_to_reg_q <= 1'b0;
      ex_branch_q      <= 1'b0;  ex_branch_not_q <= 1'b0;
      ex_rs_q          <= '0;    ex_rt_q         <= '0;    ex_rd_q     <= '0;
      mem_read_q       <= 1'b0;  mem_write_q     <= 1'b0;
      mem_reg_write_q  <= 1'b0;  mem_mem_to_reg_q <= 1'b0; mem_dst_q   <= '0;
      wb_reg_write_q   <= 1'b0;  wb_mem_to_reg_q <= 1'b0;  wb_dst_q    <= '0;
      stall_cnt_q      <= '0;    flush_cnt_q     <= '0;
    end else begin
      ex_reg_dst_q     <= ex_reg_dst_d;     ex_alu_src_q    <= ex_alu_src_d;
      ex_alu_op_q      <= ex_alu_op_d;
      ex_mem_read_q    <= ex_mem_read_d;    ex_mem_write_q  <= ex_mem_write_d;
      ex_reg_write_q   <= ex_reg_write_d;   ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_branch_q      <= ex_branch_d;      ex_branch_not_q <= ex_branch_not_d;
      ex_rs_q          <= ex_rs_d;          ex_rt_q         <= ex_rt_d;
      ex_rd_q          <= ex_rd_d;
      mem_read_q       <= mem_read_d;       mem_write_q     <= mem_write_d;
      mem_reg_write_q  <= mem_reg_write_d;  mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_dst_q        <= mem_dst_d;
      wb_reg_write_q   <= wb_reg_write_d;   wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_dst_q         <= wb_dst_d;
      stall_cnt_q      <= stall_cnt_d;      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign ex_reg_dst    = ex_reg_dst_q;
  assign ex_alu_src    = ex_alu_src_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_dst        = wb_dst_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed scoreboard bench for pipe_control_unit.
// The driver applies one ID instruction per cycle and queues the expected
// output values tagged with that cycle; the monitor checks them at negedge.
module tb_pipe_control_unit;

  localparam int unsigned CNT_W = 4;
`ifdef PIPE_CTRL_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_J = 6'h02, OP_ADDI = 6'h08, OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_NOP = 6'h3f;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [5:0] id_opcode = OP_NOP;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic ex_zero = 1'b0;
  logic ex_reg_dst, ex_alu_src, mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
  logic pc_write, ifid_write, ifid_flush;
  logic [1:0] ex_alu_op, pc_sel, fwd_a, fwd_b;
  logic [4:0] wb_dst;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_control_unit #(.OP_W(6), .REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_zero(ex_zero), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {
    F_EX_REG_DST, F_EX_ALU_SRC, F_EX_ALU_OP, F_MEM_READ, F_MEM_WRITE, F_WB_REG_WRITE,
    F_WB_MEM_TO_REG, F_WB_DST, F_PC_WRITE, F_IFID_WRITE, F_IFID_FLUSH, F_PC_SEL,
    F_FWD_A, F_FWD_B, F_STALL_CNT, F_FLUSH_CNT
  } fld_e;

  typedef struct {
    int          cyc;
    fld_e        fld;
    int unsigned val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_vec = 0, n_miss = 0;
  int unsigned exp_stall = 0, exp_flush = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned actual(fld_e f);
    case (f)
      F_EX_REG_DST:    return 32'(ex_reg_dst);
      F_EX_ALU_SRC:    return 32'(ex_alu_src);
      F_EX_ALU_OP:     return 32'(ex_alu_op);
      F_MEM_READ:      return 32'(mem_read);
      F_MEM_WRITE:     return 32'(mem_write);
      F_WB_REG_WRITE:  return 32'(wb_reg_write);
      F_WB_MEM_TO_REG: return 32'(wb_mem_to_reg);
      F_WB_DST:        return 32'(wb_dst);
      F_PC_WRITE:      return 32'(pc_write);
      F_IFID_WRITE:    return 32'(ifid_write);
      F_IFID_FLUSH:    return 32'(ifid_flush);
      F_PC_SEL:        return 32'(pc_sel);
      F_FWD_A:         return 32'(fwd_a);
      F_FWD_B:         return 32'(fwd_b);
      F_STALL_CNT:     return 32'(stall_cnt);
      default:         return 32'(flush_cnt);
    endcase
  endfunction

  // monitor: every cycle the DUT presents its outputs, pop and compare this cycle's entries
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_miss++;
        $display("FAIL %s %s: entry for cycle %0d never sampled", e.tag, e.fld.name(), e.cyc);
      end else if (actual(e.fld) !== e.val) begin
        n_miss++;
        $display("FAIL %s %s: got %0d expected %0d", e.tag, e.fld.name(), actual(e.fld), e.val);
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z);
    @(posedge clk);
    #1;
    id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
  endtask

  task automatic chk(input fld_e f, input int unsigned v, input string tag);
    exp_t e;
    e.cyc = cyc; e.fld = f; e.val = v; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk(F_EX_REG_DST, 0, tag);   chk(F_EX_ALU_SRC, 0, tag);   chk(F_EX_ALU_OP, 0, tag);
    chk(F_MEM_READ, 0, tag);     chk(F_MEM_WRITE, 0, tag);    chk(F_WB_REG_WRITE, 0, tag);
    chk(F_WB_MEM_TO_REG, 0, tag); chk(F_WB_DST, 0, tag);      chk(F_PC_WRITE, 1, tag);
    chk(F_IFID_WRITE, 1, tag);   chk(F_IFID_FLUSH, 0, tag);   chk(F_PC_SEL, 0, tag);
    chk(F_FWD_A, 0, tag);        chk(F_FWD_B, 0, tag);
    chk(F_STALL_CNT, 0, tag);    chk(F_FLUSH_CNT, 0, tag);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset("reset");
    @(negedge clk); #2 rst_n = 1'b1;

    // ADDI rt=8 held in ID
    drive(OP_ADDI, 5'd0, 5'd8, 5'd0, 1'b0);
    chk(F_PC_WRITE, 1, "addi_c0"); chk(F_EX_ALU_SRC, 0, "addi_c0");
    drive(OP_ADDI, 5'd0, 5'd8, 5'd0, 1'b0);
    chk(F_EX_ALU_SRC, 1, "addi_c1"); chk(F_EX_ALU_OP, 0, "addi_c1");
    chk(F_EX_REG_DST, 0, "addi_c1"); chk(F_PC_WRITE, FWD ? 1 : 0, "addi_c1");
    drive(OP_ADDI, 5'd0, 5'd8, 5'd0, 1'b0);
    chk(F_PC_WRITE, FWD ? 1 : 0, "addi_c2");
    drive(OP_ADDI, 5'd0, 5'd8, 5'd0, 1'b0);
    exp_stall += FWD ? 0 : 2;
    chk(F_WB_REG_WRITE, 1, "addi_c3"); chk(F_WB_DST, 8, "addi_c3");
    chk(F_WB_MEM_TO_REG, 0, "addi_c3"); chk(F_STALL_CNT, exp_stall, "addi_c3");
    drain(4);

    // ANDI rt=11 then SW
    drive(OP_ANDI, 5'd0, 5'd11, 5'd0, 1'b0);
    drive(OP_SW, 5'd0, 5'd0, 5'd0, 1'b0);
    chk(F_EX_ALU_OP, 3, "andi_c1"); chk(F_EX_ALU_SRC, 1, "andi_c1");
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk(F_EX_ALU_OP, 0, "sw_c1"); chk(F_MEM_WRITE, 0, "andi_c2");
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk(F_MEM_WRITE, 1, "sw_c2"); chk(F_WB_REG_WRITE, 1, "andi_c3"); chk(F_WB_DST, 11, "andi_c3");
    drain(3);

    // load-use: LW rt=9 then R rs=9
    drive(OP_LW, 5'd0, 5'd9, 5'd0, 1'b0);
    chk(F_PC_WRITE, 1, "lu_c0");
    drive(OP_R, 5'd9, 5'd0, 5'd10, 1'b0);
    chk(F_PC_WRITE, 0, "lu_c1"); chk(F_IFID_WRITE, 0, "lu_c1");
    chk(F_IFID_FLUSH, 0, "lu_c1"); chk(F_PC_SEL, 0, "lu_c1");
    chk(F_STALL_CNT, exp_stall, "lu_c1");
    drive(OP_R, 5'd9, 5'd0, 5'd10, 1'b0);
    chk(F_EX_ALU_SRC, 0, "lu_c2"); chk(F_EX_REG_DST, 0, "lu_c2"); chk(F_MEM_READ, 1, "lu_c2");
    chk(F_PC_WRITE, FWD ? 1 : 0, "lu_c2"); chk(F_STALL_CNT, exp_stall + 1, "lu_c2");
    drive(OP_R, 5'd9, 5'd0, 5'd10, 1'b0);
    exp_stall += FWD ? 1 : 2;
    chk(F_PC_WRITE, 1, "lu_c3"); chk(F_WB_MEM_TO_REG, 1, "lu_c3"); chk(F_WB_DST, 9, "lu_c3");
    chk(F_EX_REG_DST, FWD ? 1 : 0, "lu_c3"); chk(F_STALL_CNT, exp_stall, "lu_c3");
    drain(4);

    // BEQ taken
    drive(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    chk(F_PC_SEL, 0, "beq_c0");
    drive(OP_ADDI, 5'd0, 5'd4, 5'd0, 1'b1);
    chk(F_PC_SEL, 1, "beq_t_c1"); chk(F_IFID_FLUSH, 1, "beq_t_c1"); chk(F_PC_WRITE, 1, "beq_t_c1");
    drive(OP_ADDI, 5'd0, 5'd4, 5'd0, 1'b1);
    exp_flush += 1;
    chk(F_EX_ALU_SRC, 0, "beq_t_c2"); chk(F_PC_SEL, 0, "beq_t_c2");
    chk(F_IFID_FLUSH, 0, "beq_t_c2"); chk(F_FLUSH_CNT, exp_flush, "beq_t_c2");
    drain(4);
    // BEQ not taken
    drive(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    drive(OP_ADDI, 5'd0, 5'd4, 5'd0, 1'b0);
    chk(F_PC_SEL, 0, "beq_n_c1"); chk(F_IFID_FLUSH, 0, "beq_n_c1");
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk(F_EX_ALU_SRC, 1, "beq_n_c2"); chk(F_FLUSH_CNT, exp_flush, "beq_n_c2");
    drain(3);
    // BEQ taken beats J in ID
    drive(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    drive(OP_J, 5'd0, 5'd0, 5'd0, 1'b1);
    chk(F_PC_SEL, 1, "beq_j_c1"); chk(F_IFID_FLUSH, 1, "beq_j_c1");
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    exp_flush += 1;
    chk(F_FLUSH_CNT, exp_flush, "beq_j_c2");
    drain(3);

    // BNE taken while a stall is requested
    drive(OP_LW, 5'd0, 5'd9, 5'd0, 1'b0);
    drive(OP_BNE, 5'd1, 5'd2, 5'd0, 1'b0);
    drive(OP_R, 5'd9, 5'd0, 5'd10, 1'b0);
    chk(F_PC_SEL, 1, "bne_c2"); chk(F_PC_WRITE, 1, "bne_c2");
    chk(F_IFID_WRITE, 1, "bne_c2"); chk(F_IFID_FLUSH, 1, "bne_c2");
    drive(OP_R, 5'd9, 5'd0, 5'd10, 1'b0);
    exp_flush += 1;
    chk(F_STALL_CNT, exp_stall, "bne_c3"); chk(F_FLUSH_CNT, exp_flush, "bne_c3");
    chk(F_PC_SEL, 0, "bne_c3");
    drain(4);

    // plain jump
    drive(OP_J, 5'd0, 5'd0, 5'd0, 1'b0);
    chk(F_PC_SEL, 2, "j_c0"); chk(F_IFID_FLUSH, 1, "j_c0"); chk(F_PC_WRITE, 1, "j_c0");
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    exp_flush += 1;
    chk(F_EX_REG_DST, 0, "j_c1"); chk(F_FLUSH_CNT, exp_flush, "j_c1");
    drain(3);
    // jump held off by a stall
    drive(OP_LW, 5'd0, 5'd9, 5'd0, 1'b0);
    drive(OP_J, 5'd9, 5'd0, 5'd0, 1'b0);
    chk(F_PC_SEL, 0, "j_st_c1"); chk(F_IFID_FLUSH, 0, "j_st_c1"); chk(F_PC_WRITE, 0, "j_st_c1");
    drive(OP_J, 5'd9, 5'd0, 5'd0, 1'b0);
    chk(F_PC_SEL, FWD ? 2 : 0, "j_st_c2");
    drive(OP_J, 5'd9, 5'd0, 5'd0, 1'b0);
    chk(F_PC_SEL, 2, "j_st_c3"); chk(F_IFID_FLUSH, 1, "j_st_c3");
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    exp_flush += FWD ? 2 : 1;
    exp_stall += FWD ? 1 : 2;
    chk(F_FLUSH_CNT, exp_flush, "j_st_c4"); chk(F_STALL_CNT, exp_stall, "j_st_c4");
    drain(3);

    // ADD rd=3 followed directly by ADD rs=3 rt=3 (held)
    drive(OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
    drive(OP_R, 5'd3, 5'd3, 5'd4, 1'b0);
    chk(F_PC_WRITE, FWD ? 1 : 0, "fw1_c1");
    drive(OP_R, 5'd3, 5'd3, 5'd4, 1'b0);
    chk(F_PC_WRITE, FWD ? 1 : 0, "fw1_c2");
    chk(F_FWD_A, FWD ? 2 : 0, "fw1_c2"); chk(F_FWD_B, FWD ? 2 : 0, "fw1_c2");
    drive(OP_R, 5'd3, 5'd3, 5'd4, 1'b0);
    exp_stall += FWD ? 0 : 2;
    chk(F_PC_WRITE, 1, "fw1_c3");
    chk(F_FWD_A, FWD ? 1 : 0, "fw1_c3"); chk(F_FWD_B, FWD ? 1 : 0, "fw1_c3");
    chk(F_STALL_CNT, exp_stall, "fw1_c3");
    drain(4);
    // ADD rd=5, unrelated ADDI, then R rs=5
    drive(OP_R, 5'd1, 5'd2, 5'd5, 1'b0);
    drive(OP_ADDI, 5'd0, 5'd6, 5'd0, 1'b0);
    drive(OP_R, 5'd5, 5'd0, 5'd7, 1'b0);
    chk(F_PC_WRITE, FWD ? 1 : 0, "fw2_c2");
    drive(OP_R, 5'd5, 5'd0, 5'd7, 1'b0);
    exp_stall += FWD ? 0 : 1;
    chk(F_PC_WRITE, 1, "fw2_c3"); chk(F_FWD_A, FWD ? 1 : 0, "fw2_c3");
    chk(F_FWD_B, 0, "fw2_c3"); chk(F_STALL_CNT, exp_stall, "fw2_c3");
    drain(4);

    // saturate stall_cnt with repeated load-use
    for (int i = 0; i < 60; i++) drive(OP_LW, 5'd9, 5'd9, 5'd0, 1'b0);
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk(F_STALL_CNT, 15, "sat");
    drain(4);

    // asynchronous reset in the middle of a stall
    drive(OP_LW, 5'd0, 5'd9, 5'd0, 1'b0);
    drive(OP_R, 5'd9, 5'd0, 5'd10, 1'b0);
    chk(F_PC_WRITE, 0, "pre_rst"); chk(F_STALL_CNT, 15, "pre_rst");
    drive(OP_R, 5'd9, 5'd0, 5'd10, 1'b0);
    #1 rst_n = 1'b0;
    chk_reset("async_rst");
    @(negedge clk); #2 rst_n = 1'b1;
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk(F_STALL_CNT, 0, "post_rst"); chk(F_MEM_READ, 0, "post_rst");

    drain(2);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard: %0d entries left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
